// File: rtl/button_event_sched_pkg.sv
// Shared definitions for the button event scheduler.
//   btn_state_t : per-button press FSM encoding (LOCK, IDLE, COUNT, HELD)
//   EVT_SHORT / EVT_LONG : event kind values carried on evt_long
//   id_width()  : width of a button index for a given button count
package button_event_sched_pkg;

    typedef enum logic [1:0] {
        ST_LOCK  = 2'd0,
        ST_IDLE  = 2'd1,
        ST_COUNT = 2'd2,
        ST_HELD  = 2'd3
    } btn_state_t;

    localparam logic EVT_SHORT = 1'b0;
    localparam logic EVT_LONG  = 1'b1;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/button_event_sched_fsm.sv
// Per-button press classifier: turns one debounced level into short/long
// press events, measuring press duration in ms ticks.
//   clk, reset  : clock, synchronous active-low reset
//   ms_tick     : 1-cycle pulse once per millisecond
//   btn_level   : debounced level, 1 = pressed
//   evt_raise   : 1-cycle pulse, an event is raised this cycle
//   evt_kind    : kind of the raised event (EVT_SHORT / EVT_LONG)
//
// state | meaning
// LOCK  | after reset; wait for release so a button held through reset is ignored
// IDLE  | released, waiting for a press
// COUNT | pressed, counting ms toward the long-press threshold
// HELD  | long event already raised; wait for release silently
module btn_press_fsm
    import button_event_sched_pkg::*;
#(
    parameter int LONG_MS = 5000
) (
    input  logic clk,
    input  logic reset,
    input  logic ms_tick,
    input  logic btn_level,
    output logic evt_raise,
    output logic evt_kind
);

    localparam logic [15:0] LONG_VAL = 16'(LONG_MS);

    btn_state_t  state, state_nxt;
    logic [15:0] dur, dur_nxt;
    logic        at_thresh;

    // The tick that would bring dur to LONG_MS; the long event takes
    // priority over a release seen in the same cycle.
    assign at_thresh = ms_tick && (dur == LONG_VAL - 16'd1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_LOCK;
            dur   <= '0;
        end else begin
            state <= state_nxt;
            dur   <= dur_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dur_nxt   = dur;
        evt_raise = 1'b0;
        evt_kind  = EVT_SHORT;
        case (state)
            ST_LOCK: begin
                if (!btn_level) state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (btn_level) begin
                    dur_nxt   = '0;
                    state_nxt = ST_COUNT;
                end
            end
            ST_COUNT: begin
                if (ms_tick && (dur != LONG_VAL)) dur_nxt = dur + 16'd1;
                if (at_thresh) begin
                    evt_raise = 1'b1;
                    evt_kind  = EVT_LONG;
                    state_nxt = ST_HELD;
                end else if (!btn_level) begin
                    evt_raise = 1'b1;
                    evt_kind  = EVT_SHORT;
                    state_nxt = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (!btn_level) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_LOCK;
        endcase
    end

endmodule

// File: rtl/button_event_sched.sv
// Button event scheduler: classifies debounced button levels into short
// and long press events, queues one event per button and delivers them on
// a single valid/ready port with round-robin arbitration.
//   clk, reset  : clock, synchronous active-low reset
//   btn_level   : debounced levels, 1 = pressed
//   evt_valid   : an event is presented
//   evt_ready   : consumer accepts the presented event
//   evt_id      : index of the button that produced the event
//   evt_long    : 1 = long press, 0 = short press
//   overflow    : sticky per-button dropped-event flags
module button_event_sched
    import button_event_sched_pkg::*;
#(
    parameter  int N_BTN    = 4,
    parameter  int TICK_DIV = 50000,
    parameter  int LONG_MS  = 5000,
    localparam int ID_W     = id_width(N_BTN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_level,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_long,
    output logic [N_BTN-1:0] overflow
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [TICK_W-1:0] tick_cnt;
    logic              ms_tick;
    logic [N_BTN-1:0]  raise, raise_kind;
    logic [N_BTN-1:0]  pend, kind, grant_vec;
    logic [ID_W-1:0]   last, gnt_idx;
    logic              gnt_found, out_free, grant;
    int                idx;

    assign ms_tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (!reset)       tick_cnt <= '0;
        else if (ms_tick) tick_cnt <= '0;
        else              tick_cnt <= tick_cnt + TICK_W'(1);
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_press_fsm #(.LONG_MS(LONG_MS)) u_fsm (
            .clk       (clk),
            .reset     (reset),
            .ms_tick   (ms_tick),
            .btn_level (btn_level[i]),
            .evt_raise (raise[i]),
            .evt_kind  (raise_kind[i])
        );
    end

    // Round-robin search starting just after the last granted button.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = last;
        idx       = 0;
        for (int k = 1; k <= N_BTN; k++) begin
            idx = (int'(last) + k) % N_BTN;
            if (!gnt_found && pend[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'(idx);
            end
        end
    end

    // The output register can take a new event when empty or being drained.
    assign out_free = !evt_valid || evt_ready;
    assign grant    = out_free && gnt_found;

    always_comb begin
        grant_vec = '0;
        if (grant) grant_vec[gnt_idx] = 1'b1;
    end

    // A new event may land on a slot that is being granted this cycle;
    // only a slot that stays occupied causes a drop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pend     <= '0;
            kind     <= '0;
            overflow <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (raise[i]) begin
                    if (pend[i] && !grant_vec[i]) begin
                        overflow[i] <= 1'b1;
                    end else begin
                        pend[i] <= 1'b1;
                        kind[i] <= raise_kind[i];
                    end
                end else if (grant_vec[i]) begin
                    pend[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            evt_valid <= 1'b0;
            evt_id    <= '0;
            evt_long  <= 1'b0;
            last      <= ID_W'(N_BTN - 1);
        end else if (grant) begin
            evt_valid <= 1'b1;
            evt_id    <= gnt_idx;
            evt_long  <= kind[gnt_idx];
            last      <= gnt_idx;
        end else if (evt_ready) begin
            evt_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_event_sched.sv
// Self-checking bench for button_event_sched with TICK_DIV=10, LONG_MS=5.
// Per-cycle vector table for the single-cycle-exact scenarios, followed by
// hand-written sequences for backpressure/overflow and mid-operation reset.
module tb_button_event_sched;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] btn_level = 4'b0000;
    logic       evt_ready = 1'b0;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic       evt_long;
    logic [3:0] overflow;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    button_event_sched #(.N_BTN(4), .TICK_DIV(10), .LONG_MS(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_level (btn_level),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_long  (evt_long),
        .overflow  (overflow)
    );

    typedef struct {
        logic       rst_n;
        logic [3:0] btn;
        logic       rdy;
        logic       chk_all;
        logic       exp_valid;
        logic [1:0] exp_id;
        logic       exp_long;
        int         tag;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst_n, input logic [3:0] btn, input logic rdy,
                                input logic ev, input logic [1:0] id, input logic lg,
                                input int tag);
        vec_t v;
        v.rst_n = rst_n; v.btn = btn; v.rdy = rdy; v.chk_all = !rst_n;
        v.exp_valid = ev; v.exp_id = id; v.exp_long = lg; v.tag = tag;
        vecs.push_back(v);
    endfunction

    function automatic void add_n(input int n, input logic [3:0] btn, input logic rdy,
                                  input int tag);
        for (int i = 0; i < n; i++) add(1'b1, btn, rdy, 1'b0, 2'd0, 1'b0, tag);
    endfunction

    function automatic void add_reset(input logic [3:0] btn, input int tag);
        for (int i = 0; i < 2; i++) add(1'b0, btn, 1'b0, 1'b0, 2'd0, 1'b0, tag);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int tag, input logic [3:0] act,
                         input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (scenario %0d): got %0h expected %0h", name, tag, act, exp);
        end
    endtask

    task automatic press(input logic [3:0] btn);
        btn_level = btn;  step(); step();
        btn_level = 4'b0; step(); step();
    endtask

    task automatic do_reset();
        reset = 1'b0; btn_level = 4'b0; evt_ready = 1'b0;
        step(); step();
        reset = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // 1: button held through reset, released at ~10 ms: no event
        add_reset(4'b0001, 1);
        add_n(100, 4'b0001, 1'b0, 1);
        add_n(20, 4'b0000, 1'b0, 1);

        // 2: short press on button 2, event 2 cycles after release
        add_reset(4'b0000, 2);
        add_n(1, 4'b0000, 1'b1, 2);
        add_n(20, 4'b0100, 1'b1, 2);
        add_n(1, 4'b0000, 1'b1, 2);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0, 2);
        add_n(4, 4'b0000, 1'b1, 2);

        // 3: long press on button 1; threshold tick at the 50th edge after reset
        add_reset(4'b0000, 3);
        add_n(1, 4'b0000, 1'b1, 3);
        add_n(49, 4'b0010, 1'b1, 3);
        add(1'b1, 4'b0010, 1'b1, 1'b1, 2'd1, 1'b1, 3);
        add_n(150, 4'b0010, 1'b1, 3);
        add_n(10, 4'b0000, 1'b1, 3);

        // 4: simultaneous 0,1,3 held back, then delivered back to back; then 0,3 pair
        add_reset(4'b0000, 4);
        add_n(1, 4'b0000, 1'b0, 4);
        add_n(3, 4'b1011, 1'b0, 4);
        add_n(1, 4'b0000, 1'b0, 4);
        add(1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4);
        add(1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4);
        add(1'b1, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b0, 4);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 4);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4);
        add_n(1, 4'b0000, 1'b1, 4);
        add_n(3, 4'b1001, 1'b1, 4);
        add_n(1, 4'b0000, 1'b1, 4);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 4);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 4);
        add_n(1, 4'b0000, 1'b1, 4);

        // 5: after granting button 2, pending 0,1,3 are served as 3,0,1
        add_reset(4'b0000, 5);
        add_n(1, 4'b0000, 1'b0, 5);
        add_n(2, 4'b0100, 1'b0, 5);
        add_n(1, 4'b0000, 1'b0, 5);
        add(1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 5);
        add(1'b1, 4'b1011, 1'b0, 1'b1, 2'd2, 1'b0, 5);
        add(1'b1, 4'b1011, 1'b0, 1'b1, 2'd2, 1'b0, 5);
        add(1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 5);
        add(1'b1, 4'b0000, 1'b0, 1'b1, 2'd2, 1'b0, 5);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0, 5);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0, 5);
        add(1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0, 5);
        add_n(1, 4'b0000, 1'b1, 5);

        for (int i = 0; i < vecs.size(); i++) begin
            reset     = vecs[i].rst_n;
            btn_level = vecs[i].btn;
            evt_ready = vecs[i].rdy;
            step();
            check("evt_valid", vecs[i].tag, 4'(evt_valid), 4'(vecs[i].exp_valid));
            if (vecs[i].exp_valid || vecs[i].chk_all) begin
                check("evt_id", vecs[i].tag, 4'(evt_id), 4'(vecs[i].exp_id));
                check("evt_long", vecs[i].tag, 4'(evt_long), 4'(vecs[i].exp_long));
            end
            check("overflow", vecs[i].tag, overflow, 4'b0000);
        end

        // 6: backpressure on button 0: one presented, one pending, one dropped
        do_reset();
        press(4'b0001);
        check("bp first valid", 6, 4'(evt_valid), 4'd1);
        check("bp first id", 6, 4'(evt_id), 4'd0);
        press(4'b0001);
        check("bp stable valid", 6, 4'(evt_valid), 4'd1);
        check("bp stable id", 6, 4'(evt_id), 4'd0);
        check("bp no overflow yet", 6, overflow, 4'b0000);
        press(4'b0001);
        check("bp overflow", 6, overflow, 4'b0001);
        check("bp still valid", 6, 4'(evt_valid), 4'd1);
        evt_ready = 1'b1;
        n = 0;
        repeat (6) begin
            if (evt_valid) n++;
            step();
        end
        check("bp delivered count", 6, 4'(n), 4'd2);
        check("bp overflow sticky", 6, overflow, 4'b0001);

        // 7: reset while an event is presented and another pending
        do_reset();
        press(4'b0011);
        check("mr valid before", 7, 4'(evt_valid), 4'd1);
        press(4'b0010);
        check("mr overflow before", 7, overflow, 4'b0010);
        reset = 1'b0;
        step();
        check("mr valid after reset", 7, 4'(evt_valid), 4'd0);
        check("mr overflow after reset", 7, overflow, 4'b0000);
        check("mr id after reset", 7, 4'(evt_id), 4'd0);
        reset = 1'b1;
        evt_ready = 1'b1;
        n = 0;
        repeat (20) begin
            if (evt_valid) n++;
            step();
        end
        check("mr stale events", 7, 4'(n), 4'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
